servo_array_driver: RTL and testbench
=====================================

# servo_array_driver

Parametrised N-channel hobby-servo driver for the solar tracker. One shared microsecond prescaler and PWM period counter serve all channels. Each channel has its own pulse-width register, button/sweep direction logic, soft upper limit, and limit flag. It replaces one-servo-per-instance driving for the horizontal and vertical axes, and any added axes. Pulse widths change only at period boundaries, so every output pulse is glitch-free.

## Interface
Parameters:
- `N_CH`, 2: number of servo channels
- `PW_W`, 16: width of pulse-width and counter fields (µs units)
- `CLK_DIV`, 100: CLK cycles per 1 µs tick (100 MHz → 1 MHz)
- `PERIOD_US`, 20000: PWM period in µs
- `PW_MIN`, 500: hard lower pulse width, µs
- `PW_MAX`, 2500: hard upper pulse width, µs
- `PW_INIT`, 1500: pulse width after reset, µs
- `STEP_US`, 10: pulse-width change per period while moving

Ports:
- `CLK`, in, 1: system clock
- `RST`, in, 1: asynchronous, active-high reset
- `BTN_0`, in, N_CH: per-channel request to increase width (ccw)
- `BTN_1`, in, N_CH: per-channel request to decrease width (cw)
- `ES`, in, N_CH: per-channel enable for autonomous sweep
- `pulseWidth_max`, in, N_CH*PW_W: per-channel soft upper limit, µs
- `SERVO`, out, N_CH: PWM outputs
- `servo_position`, out, N_CH*PW_W: current pulse width per channel, µs
- `PWM_limit`, out, N_CH: channel is at its effective upper limit
- `direction`, out, 2*N_CH: per-channel motion code (00 stop, 01 ccw, 10 cw)
- `period_start`, out, 1: one-CLK pulse on the first cycle of each PWM period

## Operation
- **Prescaler:** counts 0..CLK_DIV-1 and emits `tick` on the terminal count.
- **Period counter `us_cnt`:** advances on `tick` and wraps PERIOD_US-1 → 0. The wrap cycle is the period boundary `pb`.
- **Output:** `SERVO[i]` = 1 when `us_cnt < pw[i]`, registered.
- **Effective upper limit:** `hi[i]` = min(`pulseWidth_max[i]`, PW_MAX). If `hi[i]` < PW_MIN, then `hi[i]` = PW_MIN.
- **Button mode (`ES[i]`=0):** `direction[i]` is registered from the buttons every CLK.
  - 10 → 01
  - 01 → 10
  - 00 or 11 → 00
- **Sweep mode (`ES[i]`=1):** buttons are ignored. An internal sweep state machine per channel has states UP and DOWN.
  - Entry state is UP.
  - UP → DOWN when `pw` reaches `hi`. DOWN → UP when `pw` reaches PW_MIN.
  - `direction` reports 01 in UP and 10 in DOWN.
  - Deasserting `ES` returns the channel to button mode on the next CLK and resets the sweep state to UP.
- **Width update, only on `pb`:**
  - 01: `pw` = min(`pw`+STEP_US, `hi`)
  - 10: `pw` = max(`pw`−STEP_US, PW_MIN)
  - 00: hold
  - Independent of direction, if `pw` > `hi`, then `pw` = `hi` (soft-limit lowered below current position).
  - Arithmetic uses PW_W+1 bits, with no wrap-around.
- **Limit flag:** `PWM_limit[i]` = (`pw[i]` ≥ `hi[i]`), registered.

## Timing
- **Reset values:**
  - `us_cnt` and prescaler = 0
  - `pw` = PW_INIT, so `servo_position` = PW_INIT
  - `SERVO` = 0, `direction` = 00, `PWM_limit` = 0, `period_start` = 0
  - sweep state = UP
- Reset is honoured mid-period; the first period after release starts at `us_cnt` = 0.
- **`direction`:** 1 CLK after a button or `ES` change.
- **`pw` update:** on the `pb` cycle, using the `direction` value registered before `pb`.
- **`SERVO`:** the new width takes effect in the period that starts at that `pb`. Output is 1 CLK behind the `us_cnt` compare.
- **Other outputs:** `period_start` and `PWM_limit` follow 1 CLK after `pb` / `pw` change.
- **Both limits in one update:** reaching `hi` and a sweep reversal in the same `pb` are applied together. The state flips, and the next `pb` moves away from the limit.
- **pw = 0:** `SERVO` stays low for the whole period. This is only reachable if PW_MIN = 0.

## Structure
- **Shared package `servo_pkg`:**
  - direction codes DIR_STOP, DIR_CCW, DIR_CW
  - sweep state encoding
  - default timing constants
- **Top level:** the existing tick counter module (TickCounterRst, MAX=CLK_DIV) provides the prescaler, plus the shared `us_cnt`.
- **Sub-module `servo_channel`:** one per channel, in a generate loop. It holds the direction decode, sweep FSM, `pw` register, compare, and limit flag.

## Test plan
Bench parameters: CLK_DIV=2, PERIOD_US=100, PW_MIN=10, PW_MAX=50, PW_INIT=30, STEP_US=5, N_CH=2.

1. **Reset mid-period:** assert `RST` while `SERVO` is high → all outputs reset immediately. After release, `SERVO[0]` is high for 60 CLK (30 µs) out of every 200 CLK.
2. **Button increase:** hold `BTN_0[0]`=1 → `direction[0]`=01 one CLK later. `servo_position[0]` steps 35, 40, 45, 50 at successive `pb`, then holds 50 with `PWM_limit[0]`=1. Channel 1 stays at 30.
3. **Both buttons:** `BTN_0`=`BTN_1`=1 → `direction`=00 and `pw` unchanged across 3 periods.
4. **Sweep:** `ES[1]`=1 and `pulseWidth_max[1]`=40 → `pw` goes 35, 40, 35, 30 … 10, 15, with `direction` toggling 01 ↔ 10 at 40 and 10.
5. **Soft limit lowered:** with `pw`=50, set `pulseWidth_max`=20 → `pw`=20 at the next `pb`, `PWM_limit`=1.
6. **Button decrease to floor:** `BTN_1` held from 30 → 25, 20, 15, 10, then holds 10. `PWM_limit`=0 throughout.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared definitions for the servo array driver.
//   dir_e     : per-channel motion code driven on `direction`
//   sweep_e   : state encoding of the per-channel autonomous sweep machine
//   DEF_*     : default timing constants (100 MHz clock, 50 Hz hobby-servo frame)
//   btn_to_dir: maps the two request buttons to a motion code
package servo_pkg;

  typedef enum logic [1:0] {
    DIR_STOP = 2'b00,
    DIR_CCW  = 2'b01,   // pulse width grows
    DIR_CW   = 2'b10    // pulse width shrinks
  } dir_e;

  typedef enum logic {
    SWEEP_UP   = 1'b0,
    SWEEP_DOWN = 1'b1
  } sweep_e;

  localparam int DEF_N_CH      = 2;
  localparam int DEF_PW_W      = 16;
  localparam int DEF_CLK_DIV   = 100;
  localparam int DEF_PERIOD_US = 20000;
  localparam int DEF_PW_MIN    = 500;
  localparam int DEF_PW_MAX    = 2500;
  localparam int DEF_PW_INIT   = 1500;
  localparam int DEF_STEP_US   = 10;

  // Exactly one button pressed selects a direction; none or both means stop.
  function automatic dir_e btn_to_dir(input logic inc, input logic dec);
    case ({inc, dec})
      2'b10:   return DIR_CCW;
      2'b01:   return DIR_CW;
      default: return DIR_STOP;
    endcase
  endfunction

endpackage

// File: rtl/servo_channel.sv
// servo_channel: one servo output with its own width register and motion logic.
//   clk, rst       : clock, asynchronous active-high reset
//   pb             : period boundary strobe (shared us_cnt wraps this cycle)
//   us_cnt         : shared microsecond position inside the PWM period
//   btn_inc/btn_dec: button requests (increase / decrease width)
//   es             : autonomous sweep enable
//   pw_max         : soft upper limit in microseconds
//   servo          : registered PWM output
//   position       : current pulse width in microseconds
//   limit          : registered "width at effective upper limit" flag
//   dir            : registered motion code (servo_pkg::dir_e)
module servo_channel
  import servo_pkg::*;
#(
  parameter int PW_W    = DEF_PW_W,
  parameter int PW_MIN  = DEF_PW_MIN,
  parameter int PW_MAX  = DEF_PW_MAX,
  parameter int PW_INIT = DEF_PW_INIT,
  parameter int STEP_US = DEF_STEP_US
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pb,
  input  logic [PW_W-1:0] us_cnt,
  input  logic            btn_inc,
  input  logic            btn_dec,
  input  logic            es,
  input  logic [PW_W-1:0] pw_max,
  output logic            servo,
  output logic [PW_W-1:0] position,
  output logic            limit,
  output logic [1:0]      dir
);

  // One extra bit so pw + STEP_US can never wrap before it is clamped.
  localparam logic [PW_W:0]   MIN_X  = (PW_W+1)'(PW_MIN);
  localparam logic [PW_W:0]   MAX_X  = (PW_W+1)'(PW_MAX);
  localparam logic [PW_W:0]   STEP_X = (PW_W+1)'(STEP_US);
  localparam logic [PW_W-1:0] INIT   = PW_W'(PW_INIT);

  logic [PW_W-1:0] pw_q;
  logic [PW_W:0]   pw_x;
  logic [PW_W:0]   hi_x;
  logic [PW_W:0]   pw_next;
  dir_e            dir_q;
  dir_e            sweep_dir;
  sweep_e          state;
  sweep_e          state_next;

  assign pw_x = {1'b0, pw_q};

  // Effective upper limit: soft limit capped by the hard maximum, but never
  // below the hard minimum so the width range is never empty.
  // NOTE: every variable driven in always_comb gets a value on the first line
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    hi_x = {1'b0, pw_max};
    if (hi_x > MAX_X) hi_x = MAX_X;
    if (hi_x < MIN_X) hi_x = MIN_X;
  end

  // Width candidate for the next period boundary.
  always_comb begin
    pw_next = pw_x;
    case (dir_q)
      DIR_CCW: pw_next = pw_x + STEP_X;
      DIR_CW:  pw_next = (pw_x >= MIN_X + STEP_X) ? pw_x - STEP_X : MIN_X;
      default: pw_next = pw_x;
    endcase
    // Also pulls the width down when the soft limit was lowered under it.
    if (pw_next > hi_x) pw_next = hi_x;
  end

  // Sweep machine: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SWEEP_UP;
    else     state <= state_next;
  end

  // Sweep machine: next state. Reversal is judged on the width being written
  // at this boundary, so reaching a limit and turning happen together.
  always_comb begin
    state_next = state;
    if (!es) begin
      state_next = SWEEP_UP;
    end else if (pb) begin
      case (state)
        SWEEP_UP:   if (pw_next >= hi_x)  state_next = SWEEP_DOWN;
        SWEEP_DOWN: if (pw_next <= MIN_X) state_next = SWEEP_UP;
        default:    state_next = SWEEP_UP;
      endcase
    end
  end

  // Sweep machine: output decode.
  always_comb begin
    sweep_dir = (state == SWEEP_UP) ? DIR_CCW : DIR_CW;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dir_q <= DIR_STOP;
    else     dir_q <= es ? sweep_dir : btn_to_dir(btn_inc, btn_dec);
  end

  // Width changes only at the boundary, so a pulse in flight is never cut.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     pw_q <= INIT;
    else if (pb) pw_q <= pw_next[PW_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      servo <= 1'b0;
      limit <= 1'b0;
    end else begin
      servo <= (us_cnt < pw_q);
      limit <= (pw_x >= hi_x);
    end
  end

  assign position = pw_q;
  assign dir      = dir_q;

endmodule

// File: rtl/tick_counter_rst.sv
// TickCounterRst: free-running modulo-MAX counter with asynchronous reset.
//   clk  : counter clock
//   rst  : asynchronous, active-high reset (count restarts at 0)
//   tick : high for one cycle on the terminal count MAX-1
module TickCounterRst #(
  parameter int MAX = 100
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = (MAX > 1) ? $clog2(MAX) : 1;
  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] cnt;

  // NOTE: clocked state is always written with <= so every register samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/servo_array_driver.sv
// servo_array_driver: N-channel hobby-servo PWM driver.
//   CLK, RST       : system clock, asynchronous active-high reset
//   BTN_0 / BTN_1  : per-channel increase / decrease requests
//   ES             : per-channel autonomous sweep enable
//   pulseWidth_max : per-channel soft upper limit (PW_W bits per channel, us)
//   SERVO          : per-channel PWM outputs
//   servo_position : per-channel current pulse width (PW_W bits per channel, us)
//   PWM_limit      : per-channel "at effective upper limit" flag
//   direction      : per-channel motion code (2 bits per channel)
//   period_start   : one-cycle pulse on the first cycle of every PWM period
// The microsecond prescaler and the period counter are shared by all channels.
module servo_array_driver
  import servo_pkg::*;
#(
  parameter int N_CH      = DEF_N_CH,
  parameter int PW_W      = DEF_PW_W,
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int PERIOD_US = DEF_PERIOD_US,
  parameter int PW_MIN    = DEF_PW_MIN,
  parameter int PW_MAX    = DEF_PW_MAX,
  parameter int PW_INIT   = DEF_PW_INIT,
  parameter int STEP_US   = DEF_STEP_US
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N_CH-1:0]      BTN_0,
  input  logic [N_CH-1:0]      BTN_1,
  input  logic [N_CH-1:0]      ES,
  input  logic [N_CH*PW_W-1:0] pulseWidth_max,
  output logic [N_CH-1:0]      SERVO,
  output logic [N_CH*PW_W-1:0] servo_position,
  output logic [N_CH-1:0]      PWM_limit,
  output logic [2*N_CH-1:0]    direction,
  output logic                 period_start
);

  localparam logic [PW_W-1:0] US_LAST = PW_W'(PERIOD_US - 1);

  logic            tick;
  logic [PW_W-1:0] us_cnt;
  logic            pb;

  TickCounterRst #(.MAX(CLK_DIV)) u_prescaler (
    .clk  (CLK),
    .rst  (RST),
    .tick (tick)
  );

  // Boundary is the cycle on which the period counter wraps.
  assign pb = tick && (us_cnt == US_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      us_cnt       <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= pb;
      if (pb)        us_cnt <= '0;
      else if (tick) us_cnt <= us_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    servo_channel #(
      .PW_W    (PW_W),
      .PW_MIN  (PW_MIN),
      .PW_MAX  (PW_MAX),
      .PW_INIT (PW_INIT),
      .STEP_US (STEP_US)
    ) u_ch (
      .clk      (CLK),
      .rst      (RST),
      .pb       (pb),
      .us_cnt   (us_cnt),
      .btn_inc  (BTN_0[i]),
      .btn_dec  (BTN_1[i]),
      .es       (ES[i]),
      .pw_max   (pulseWidth_max[i*PW_W +: PW_W]),
      .servo    (SERVO[i]),
      .position (servo_position[i*PW_W +: PW_W]),
      .limit    (PWM_limit[i]),
      .dir      (direction[2*i +: 2])
    );
  end

endmodule

// File: tb/tb_servo_array_driver.sv
// Bench for servo_array_driver: per-period stimulus is fed to a period-level
// reference model whose predictions are queued; a monitor pops one prediction
// at every period_start and compares widths, limits, directions, PWM duty
// and period length.
module tb_servo_array_driver;

  localparam int N_CH       = 2;
  localparam int PW_W       = 16;
  localparam int CLK_DIV    = 2;
  localparam int PERIOD_US  = 100;
  localparam int PW_MIN     = 10;
  localparam int PW_MAX     = 50;
  localparam int PW_INIT    = 30;
  localparam int STEP_US    = 5;
  localparam int PERIOD_CLK = CLK_DIV * PERIOD_US;

  logic                 CLK = 1'b0;
  logic                 RST = 1'b1;
  logic [N_CH-1:0]      BTN_0 = '0;
  logic [N_CH-1:0]      BTN_1 = '0;
  logic [N_CH-1:0]      ES = '0;
  logic [N_CH*PW_W-1:0] pulseWidth_max = '0;
  logic [N_CH-1:0]      SERVO;
  logic [N_CH*PW_W-1:0] servo_position;
  logic [N_CH-1:0]      PWM_limit;
  logic [2*N_CH-1:0]    direction;
  logic                 period_start;

  servo_array_driver #(
    .N_CH(N_CH), .PW_W(PW_W), .CLK_DIV(CLK_DIV), .PERIOD_US(PERIOD_US),
    .PW_MIN(PW_MIN), .PW_MAX(PW_MAX), .PW_INIT(PW_INIT), .STEP_US(STEP_US)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .BTN_0          (BTN_0),
    .BTN_1          (BTN_1),
    .ES             (ES),
    .pulseWidth_max (pulseWidth_max),
    .SERVO          (SERVO),
    .servo_position (servo_position),
    .PWM_limit      (PWM_limit),
    .direction      (direction),
    .period_start   (period_start)
  );

  always #5 CLK = ~CLK;

  // One prediction per PWM period, checked at the period_start that ends it.
  typedef struct packed {
    logic [N_CH-1:0][15:0] pw_after;   // width presented after the boundary
    logic [N_CH-1:0][15:0] high_clk;   // SERVO high cycles during the period
    logic [N_CH-1:0]       lim;        // PWM_limit seen during the period
    logic [N_CH-1:0][1:0]  dir;        // direction seen during the period
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  // Reference state: width in us and sweep heading per channel.
  int m_pw[N_CH];
  bit m_up[N_CH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int hi_of(input int mx);
    int h;
    h = (mx > PW_MAX) ? PW_MAX : mx;
    if (h < PW_MIN) h = PW_MIN;
    return h;
  endfunction

  task automatic wait_period_start();
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!period_start && n < 2 * PERIOD_CLK);
    check("period_start_seen", {31'd0, period_start}, 32'd1);
  endtask

  // Apply one period's inputs, predict its outcome, then wait for its end.
  task automatic run_period(input logic [N_CH-1:0] b0, input logic [N_CH-1:0] b1,
                            input logic [N_CH-1:0] es, input int mx0, input int mx1);
    exp_t e;
    int   mx[N_CH];
    int   hi;
    int   d;
    mx[0] = mx0;
    mx[1] = mx1;
    BTN_0 = b0;
    BTN_1 = b1;
    ES    = es;
    pulseWidth_max = {16'(mx1), 16'(mx0)};
    e = '0;
    for (int i = 0; i < N_CH; i++) begin
      hi = hi_of(mx[i]);
      if (es[i])                d = m_up[i] ? 1 : -1;
      else if (b0[i] && !b1[i]) d = 1;
      else if (b1[i] && !b0[i]) d = -1;
      else                      d = 0;
      e.high_clk[i] = 16'(m_pw[i] * CLK_DIV);
      e.lim[i]      = (m_pw[i] >= hi);
      e.dir[i]      = (d > 0) ? 2'b01 : (d < 0) ? 2'b10 : 2'b00;
      if (d > 0)      m_pw[i] = (m_pw[i] + STEP_US > hi) ? hi : m_pw[i] + STEP_US;
      else if (d < 0) m_pw[i] = (m_pw[i] - STEP_US < PW_MIN) ? PW_MIN : m_pw[i] - STEP_US;
      if (m_pw[i] > hi) m_pw[i] = hi;
      if (!es[i])                          m_up[i] = 1'b1;
      else if (m_up[i] && m_pw[i] >= hi)       m_up[i] = 1'b0;
      else if (!m_up[i] && m_pw[i] <= PW_MIN)  m_up[i] = 1'b1;
      e.pw_after[i] = 16'(m_pw[i]);
    end
    exp_q.push_back(e);
    wait_period_start();
  endtask

  // Monitor: counts period length and SERVO duty, compares at period_start.
  initial begin
    int   cyc;
    int   high[N_CH];
    exp_t e;
    wait (mon_en);
    cyc = 0;
    for (int i = 0; i < N_CH; i++) high[i] = 0;
    forever begin
      @(negedge CLK);
      cyc++;
      for (int i = 0; i < N_CH; i++) high[i] += int'(SERVO[i]);
      if (period_start) begin
        check("period_len", cyc, PERIOD_CLK);
        if (exp_q.size() == 0) begin
          check("unexpected_period_start", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          for (int i = 0; i < N_CH; i++) begin
            check($sformatf("servo_position[%0d]", i),
                  {16'd0, servo_position[i*PW_W +: PW_W]}, {16'd0, e.pw_after[i]});
            check($sformatf("PWM_limit[%0d]", i), {31'd0, PWM_limit[i]}, {31'd0, e.lim[i]});
            check($sformatf("direction[%0d]", i), {30'd0, direction[2*i +: 2]}, {30'd0, e.dir[i]});
            check($sformatf("servo_high_clk[%0d]", i), high[i], {16'd0, e.high_clk[i]});
          end
        end
        cyc = 0;
        for (int i = 0; i < N_CH; i++) high[i] = 0;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N_CH-1:0] rb0;
    logic [N_CH-1:0] rb1;
    logic [N_CH-1:0] res;
    int              n;

    for (int i = 0; i < N_CH; i++) begin
      m_pw[i] = PW_INIT;
      m_up[i] = 1'b1;
    end

    // Reset state while reset is held.
    repeat (3) @(negedge CLK);
    check("rst_servo_position", servo_position, {16'(PW_INIT), 16'(PW_INIT)});
    check("rst_SERVO", {30'd0, SERVO}, 0);
    check("rst_direction", {28'd0, direction}, 0);
    check("rst_PWM_limit", {30'd0, PWM_limit}, 0);
    check("rst_period_start", {31'd0, period_start}, 0);

    // Reset asserted mid-period while SERVO is high and both channels move.
    pulseWidth_max = {16'd60, 16'd60};
    BTN_0 = 2'b11;
    RST = 1'b0;
    n = 0;
    while (!SERVO[0] && n < 50) begin
      @(negedge CLK);
      n++;
    end
    repeat (7) @(negedge CLK);
    check("pre_rst_SERVO0", {31'd0, SERVO[0]}, 1);
    check("pre_rst_direction", {28'd0, direction}, 32'b0101);
    #2 RST = 1'b1;
    #1;
    check("mid_rst_SERVO", {30'd0, SERVO}, 0);
    check("mid_rst_direction", {28'd0, direction}, 0);
    check("mid_rst_servo_position", servo_position, {16'(PW_INIT), 16'(PW_INIT)});
    check("mid_rst_PWM_limit", {30'd0, PWM_limit}, 0);
    BTN_0 = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    mon_en = 1'b1;

    // Button increase on channel 0 up to the hard maximum.
    repeat (6) run_period(2'b01, 2'b00, 2'b00, 60, 60);
    // Both buttons on both channels: no motion.
    repeat (3) run_period(2'b11, 2'b11, 2'b00, 60, 60);
    // Soft limit lowered below the current position of channel 0.
    repeat (3) run_period(2'b00, 2'b00, 2'b00, 20, 60);
    // Button decrease on channel 1 down to the floor.
    repeat (6) run_period(2'b00, 2'b10, 2'b00, 20, 60);
    // Sweep on channel 1 between the floor and a soft limit of 40.
    repeat (12) run_period(2'b00, 2'b00, 2'b10, 20, 40);

    // Randomized periods; sweep enables are held for a few periods at a time.
    res = '0;
    for (int k = 0; k < 40; k++) begin
      rb0 = N_CH'($urandom);
      rb1 = N_CH'($urandom);
      if (k % 4 == 0) res = ($urandom_range(0, 1) == 0) ? N_CH'($urandom) : '0;
      run_period(rb0, rb1, res, int'($urandom_range(0, 70)), int'($urandom_range(0, 70)));
    end

    repeat (3) @(negedge CLK);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
